// File: rtl/fifo_pkg.sv
// Shared defaults and depth helper for the synchronous FIFO family.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_AF_THRESH  = 12;
    localparam int DEF_AE_THRESH  = 2;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read handshake, status and error bundle between a FIFO and its user.
interface sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wfull;
    logic                  walmost_full;
    logic                  rinc;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rempty;
    logic                  ralmost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  clr_err;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output winc, wdata, rinc, clr_err,
        input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc, clr_err,
        output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered (FWFT=0) or asynchronous (FWFT=1) read.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; validity is tracked by the pointers,
    // and leaving it out keeps the array mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            logic unused_rd_ctrl;
            assign unused_rd_ctrl = &{1'b0, re, rst_n};
            assign rdata = mem[raddr];
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  rdata <= '0;
                else if (re) rdata <= mem[raddr];
            end
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, occupancy-derived flags, sticky error flags.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_THRESH  = DEF_AF_THRESH,
    parameter int AE_THRESH  = DEF_AE_THRESH,
    parameter int FWFT       = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    sync_fifo_if.slave  bus
);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(AE_THRESH);

    generate
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $fatal(1, "sync_fifo: AF_THRESH must lie in 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $fatal(1, "sync_fifo: AE_THRESH must lie in 0..DEPTH-1");
        end
    endgenerate

    logic [ADDR_WIDTH:0] wptr, rptr, count;
    logic                wfull, rempty, wr_en, rd_en;

    // NOTE: every signal driven here is assigned on every path, so no latch can form.
    always_comb begin
        count  = wptr - rptr;
        rempty = (wptr == rptr);
        wfull  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                 (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
        wr_en  = bus.winc && !wfull;
        rd_en  = bus.rinc && !rempty;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (bus.winc && wfull)       bus.overflow <= 1'b1;
            else if (bus.clr_err)        bus.overflow <= 1'b0;
            if (bus.rinc && rempty)      bus.underflow <= 1'b1;
            else if (bus.clr_err)        bus.underflow <= 1'b0;
        end
    end

    assign bus.count         = count;
    assign bus.wfull         = wfull;
    assign bus.rempty        = rempty;
    assign bus.walmost_full  = (count >= AF_LVL);
    assign bus.ralmost_empty = (count <= AE_LVL);

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FWFT       (FWFT)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (bus.wdata),
        .re    (rd_en),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (bus.rdata)
    );

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised FIFO for data buffering inside one clock domain. It keeps the established winc/wdata/wfull and rinc/rdata/rempty handshake. It adds the following, none of which the existing FIFO provides:
- configurable width and depth
- fill count
- programmable almost-full and almost-empty flags
- first-word-fall-through (FWFT) read mode
- sticky overflow and underflow error flags

Parameters:
DATA_WIDTH, 8, width of wdata and rdata.
ADDR_WIDTH, 4, depth is 2**ADDR_WIDTH entries (default 16).
AF_THRESH, 12, walmost_full asserted when count >= AF_THRESH (range 1..DEPTH).
AE_THRESH, 2, ralmost_empty asserted when count <= AE_THRESH (range 0..DEPTH-1).
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
clk  input  1  single clock; all logic samples on its rising edge.
rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk.
winc  input  1  write request; wdata is captured when accepted.
wdata  input  DATA_WIDTH  write data.
wfull  output  1  FIFO holds DEPTH entries.
walmost_full  output  1  count >= AF_THRESH.
rinc  input  1  read request.
rdata  output  DATA_WIDTH  read data; timing depends on FWFT.
rempty  output  1  FIFO holds 0 entries.
ralmost_empty  output  1  count <= AE_THRESH.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
clr_err  input  1  one-cycle pulse clears overflow and underflow.
overflow  output  1  sticky; a write was attempted while full.
underflow  output  1  sticky; a read was attempted while empty.

Behaviour:
- Pointers:
  - wptr and rptr are ADDR_WIDTH+1-bit binary registers; the MSB is the wrap bit.
  - Memory is addressed by the low ADDR_WIDTH bits, so pointers wrap naturally at DEPTH.
  - count = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
  - rempty = (wptr == rptr).
  - wfull = (low bits equal) and (MSBs differ).
- Flag timing:
  - All flags and count are combinational decodes of the registered pointers.
  - They change in the same cycle the pointers change, i.e. immediately after the accepting edge.
- Accept rules (evaluated on state at the start of the cycle):
  - A write is accepted iff winc && !wfull.
  - A read is accepted iff rinc && !rempty.
- Simultaneous winc and rinc:
  - Not full and not empty: both are accepted; count is unchanged.
  - Full: the read is accepted and the write is rejected; overflow is set; count becomes DEPTH-1.
  - Empty: the write is accepted and the read is rejected; underflow is set; count becomes 1.
- Rejected requests:
  - winc while wfull: no memory or pointer change; overflow <= 1.
  - rinc while rempty: no pointer change; rdata holds; underflow <= 1.
- Error flags:
  - overflow and underflow stay set until clr_err or reset.
  - If clr_err and a new error event occur in the same cycle, the set wins.
- FWFT=0:
  - rdata is registered from mem[rptr] on an accepted read, giving 1-cycle latency (valid the cycle after the rinc edge).
  - rdata holds its value otherwise.
- FWFT=1:
  - rdata = mem[rptr] (asynchronous read) and is valid whenever rempty = 0.
  - An accepted rinc pops the head; the next entry appears after that edge.
  - rdata is don't-care while empty.
- Write latency: data written at edge N is readable (FWFT) or poppable from edge N onward; rempty falls immediately after edge N.
- Reset values:
  - wptr = rptr = 0, count = 0, rempty = 1, wfull = 0.
  - walmost_full = (AF_THRESH == 0), effectively 0.
  - ralmost_empty = 1, rdata = 0, overflow = underflow = 0.
  - Memory contents are not reset.
- Reset mid-operation: asserting rst_n discards all entries asynchronously and forces the reset values above; the first operation is accepted on the first edge after deassertion.
- Elaboration checks: AF_THRESH outside 1..DEPTH or AE_THRESH outside 0..DEPTH-1 is a fatal elaboration error.

Decomposition:
- Package fifo_pkg holds the default DATA_WIDTH, ADDR_WIDTH and thresholds, plus the DEPTH derivation helper.
- Sub-module sync_fifo_mem is a simple dual-port RAM: synchronous write, and a read port that is registered or asynchronous per FWFT.
- Pointer, flag and error logic stay in sync_fifo.

Test Plan:
- Fill: reset, then 16 consecutive writes of 0x01..0x10 at DW=8, AW=4. Expected:
  - rempty falls after write 1.
  - walmost_full rises when count = 12.
  - wfull rises when count = 16.
  - count reaches 16.
- Overflow: from full, assert winc for 2 cycles. Expected: count stays 16, overflow = 1, memory unchanged; a clr_err pulse returns overflow to 0.
- Drain (FWFT=0): 16 reads after fill. Expected:
  - rdata = 0x01..0x10, each one cycle after its rinc.
  - ralmost_empty rises when count = 2.
  - rempty rises after the 16th read.
  - A 17th rinc sets underflow, and rdata holds 0x10.
- FWFT=1: write 0xA5 into an empty FIFO. Expected: rdata = 0xA5 in the cycle after the write edge with no rinc; rinc pops it and rempty returns to 1.
- Simultaneous access:
  - Full plus winc and rinc: count goes to 15 and overflow = 1.
  - Empty plus winc and rinc: count goes to 1, underflow = 1, and the written value is the next read.
  - Half-full plus 100 cycles of random winc/rinc: the output sequence matches a scoreboard and count never exceeds 16.
- Reset mid-stream: assert rst_n low at count = 7. Expected: count = 0, rempty = 1, rdata = 0 immediately (asynchronously); after release, a write followed by a read returns the new data.
